hazard_scoreboard: RTL

- Unified hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB); it replaces the stub stall unit and the separate forwarding unit.
- Keeps its own shadow scoreboard of the EX/MEM/WB destination registers.
- Generates the load-use stall, the IF/ID flush on a taken branch, and the EX operand forwarding selects.
- Parametrised in register address width and load-use penalty. Supports a global pipeline freeze for slow data memory.

---
 rtl/hazard_scoreboard.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard and forwarding control for the IF/ID/EX/MEM/WB pipeline.
// A shadow copy of the EX/MEM/WB destination registers drives three things:
// the load-use stall (LOAD_STALL bubbles), the IF/ID flush on a taken branch,
// and the EX operand forwarding selects (00 register, 01 WB, 10 MEM).
// mem_busy_i freezes every stored field and suppresses stall/flush.
// Optional build macro HAZARD_PERF_EN adds saturating 32-bit stall/flush cycle counters.
module hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              branch_taken_i,
    input  logic              mem_busy_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic              freeze_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_o,
    output logic [31:0]       perf_flush_o
`endif
);

    localparam int CW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } entry_t;

    entry_t            ex_q;
    entry_t            mem_q;
    entry_t            wb_q;
    logic [REG_AW-1:0] ex_rs1_q;
    logic [REG_AW-1:0] ex_rs2_q;
    logic              ex_rs1_used_q;
    logic              ex_rs2_used_q;
    logic [CW-1:0]     cnt_q;

    logic load_hit;
    logic advance;

    // Loads sitting in WB forward like any other result, so their load flag
    // is carried along for completeness but never consulted.
    logic wb_memread_unused;
    assign wb_memread_unused = wb_q.memread;

    // An entry supplies source s when it will write s and s is really read.
    // Register 0 never matches, so it can neither stall nor forward.
    function automatic logic hit(entry_t e, logic [REG_AW-1:0] s, logic used);
        return e.valid && e.regwrite && (e.rd == s) && (e.rd != '0) && used;
    endfunction

    assign advance  = !mem_busy_i;
    assign freeze_o = mem_busy_i;

    // Load-use detection, stall and branch flush.
    always_comb begin
        load_hit = 1'b0;
        stall_o  = 1'b0;
        flush_o  = 1'b0;
        if (id_valid_i && ex_q.memread &&
            (hit(ex_q, id_rs1_i, id_rs1_used_i) || hit(ex_q, id_rs2_i, id_rs2_used_i)))
            load_hit = 1'b1;
        if ((load_hit || (cnt_q != '0)) && !mem_busy_i)
            stall_o = 1'b1;
        if (branch_taken_i && id_valid_i && !stall_o && !mem_busy_i)
            flush_o = 1'b1;
    end

    // EX operand forwarding; MEM beats WB, but a load in MEM is not forwardable.
    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (hit(mem_q, ex_rs1_q, ex_rs1_used_q) && !mem_q.memread)
            fwd_a_o = 2'b10;
        else if (hit(wb_q, ex_rs1_q, ex_rs1_used_q))
            fwd_a_o = 2'b01;
        if (hit(mem_q, ex_rs2_q, ex_rs2_used_q) && !mem_q.memread)
            fwd_b_o = 2'b10;
        else if (hit(wb_q, ex_rs2_q, ex_rs2_used_q))
            fwd_b_o = 2'b01;
    end

    // Shadow pipeline: shift EX->MEM->WB, inject ID or a bubble into EX.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rs1_used_q <= 1'b0;
            ex_rs2_used_q <= 1'b0;
        end else if (advance) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (!stall_o && id_valid_i) begin
                ex_q.valid    <= 1'b1;
                ex_q.rd       <= id_rd_i;
                ex_q.regwrite <= id_regwrite_i;
                ex_q.memread  <= id_memread_i;
                ex_rs1_q      <= id_rs1_i;
                ex_rs2_q      <= id_rs2_i;
                ex_rs1_used_q <= id_rs1_used_i;
                ex_rs2_used_q <= id_rs2_used_i;
            end else begin
                ex_q          <= '0;
                ex_rs1_q      <= '0;
                ex_rs2_q      <= '0;
                ex_rs1_used_q <= 1'b0;
                ex_rs2_used_q <= 1'b0;
            end
        end
    end

    // Remaining-bubble down-counter: loaded on the first stall cycle, then
    // counts down to terminal count zero while the pipeline is not frozen.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (advance) begin
            if (cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            else if (load_hit)
                cnt_q <= CW'(LOAD_STALL - 1);
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating counts of stall and flush cycles; both are 0 while frozen.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_o <= '0;
            perf_flush_o <= '0;
        end else begin
            if (stall_o && (perf_stall_o != 32'hFFFF_FFFF))
                perf_stall_o <= perf_stall_o + 32'd1;
            if (flush_o && (perf_flush_o != 32'hFFFF_FFFF))
                perf_flush_o <= perf_flush_o + 32'd1;
        end
    end
`endif

endmodule
